// File: rtl/memory_pkg.sv
// Shared definitions for the RAM responder: FSM state encoding and latency defaults.
package memory_pkg;

  // One-hot controller states.
  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    RD_WAIT = 4'b0010,
    RD_DONE = 4'b0100,
    WR_DONE = 4'b1000
  } state_e;

  // Default number of cycles a read spends in RD_WAIT.
  localparam int unsigned DEFAULT_READ_LATENCY = 3;

  // Width of the latency counter; holds readLatency-1 for readLatency up to 15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/ram_array.sv
// Storage array: one synchronous write port, one combinational read port, no reset.
module ram_array #(
  parameter int ramWidth = 8,
  parameter int addrSize = 8
) (
  input  logic                clk,
  input  logic                we,
  input  logic [addrSize-1:0] waddr,
  input  logic [ramWidth-1:0] wdata,
  input  logic [addrSize-1:0] raddr,
  output logic [ramWidth-1:0] rdata
);

  logic [ramWidth-1:0] mem_q [0:(1 << addrSize) - 1];

  // Write port: store wdata at waddr on a strobed edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ram_responder.sv
// RAM responder: request FSM with programmable read latency in front of ram_array.
module ram_responder
  import memory_pkg::*;
#(
  parameter int ramWidth    = 8,
  parameter int addrSize    = 8,
  parameter int readLatency = DEFAULT_READ_LATENCY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                RAMreadEnable,
  input  logic                RAMwriteEnable,
  input  logic [addrSize-1:0] addr,
  input  logic [ramWidth-1:0] dataIn,
  output logic [ramWidth-1:0] dataOut,
  output logic                dataReady,
  output logic                busy
);

  // Counter load value; RD_WAIT runs until the counter reaches zero.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(readLatency - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [addrSize-1:0] locked_addr_q, locked_addr_d;
  logic [ramWidth-1:0] data_out_q, data_out_d;
  logic                data_ready_q, data_ready_d;
  logic                busy_q, busy_d;
  logic                mem_we_s;
  logic                wr_en_s;
  logic [ramWidth-1:0] mem_rdata_s;

  // A write coinciding with reset is dropped.
  assign wr_en_s = mem_we_s & ~rst;

  ram_array #(
    .ramWidth (ramWidth),
    .addrSize (addrSize)
  ) u_ram_array (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (addr),
    .wdata (dataIn),
    .raddr (locked_addr_q),
    .rdata (mem_rdata_s)
  );

  // Next-state logic: write has priority in IDLE, reads are timed by the latency counter.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    locked_addr_d = locked_addr_q;
    data_out_d    = data_out_q;
    data_ready_d  = 1'b0;
    mem_we_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (RAMwriteEnable) begin
          mem_we_s = 1'b1;
          state_d  = WR_DONE;
        end else if (RAMreadEnable) begin
          locked_addr_d = addr;
          cnt_d         = CNT_LOAD;
          state_d       = RD_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          data_out_d   = mem_rdata_s;
          data_ready_d = 1'b1;
          state_d      = RD_DONE;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      RD_DONE: state_d = IDLE;
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset; memory is not touched here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      locked_addr_q <= {addrSize{1'b0}};
      data_out_q    <= {ramWidth{1'b0}};
      data_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      locked_addr_q <= locked_addr_d;
      data_out_q    <= data_out_d;
      data_ready_q  <= data_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign dataOut   = data_out_q;
  assign dataReady = data_ready_q;
  assign busy      = busy_q;

endmodule
